// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: decodes per-stage stall requests into a hold
// vector, tracks stall runs with a two-state FSM, keeps per-source stall
// statistics and raises a sticky watchdog on over-long stall runs.
module pipeline_ctrl #(
  parameter int unsigned WDOG_LIMIT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic             clr_cnt,
  output logic [5:0]       stall,
  output logic             stall_active,
  output logic             stall_start,
  output logic [CNT_W-1:0] if_stall_cnt,
  output logic [CNT_W-1:0] id_stall_cnt,
  output logic [CNT_W-1:0] ex_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [15:0]      run_len,
  output logic             wdog_timeout
);

  typedef enum logic {RUN, STALLED} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [15:0]      WDOG_LV = 16'(WDOG_LIMIT);

  state_t                     state, state_nxt;
  logic [3:0]                 src;      // one-hot attributed source: 0 if, 1 id, 2 ex, 3 mem
  logic [15:0]                run_nxt;
  logic [3:0][CNT_W-1:0]      cnt;

  // Priority decode of requests; reset masks everything so the pipe never holds during reset.
  always_comb begin
    src   = '0;
    stall = '0;
    if (!rst) begin
      if (stallreq_from_mem) begin
        src[3] = 1'b1;
        stall  = 6'b011111;
      end else if (stallreq_from_ex) begin
        src[2] = 1'b1;
        stall  = 6'b001111;
      end else if (stallreq_from_id) begin
        src[1] = 1'b1;
        stall  = 6'b000111;
      end else if (stallreq_from_if) begin
        src[0] = 1'b1;
        stall  = 6'b000011;
      end
    end
  end

  assign stall_active = |stall[4:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // FSM next-state: follow stall_active.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stall_active)  state_nxt = STALLED;
      STALLED: if (!stall_active) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // One-cycle pulse after each RUN -> STALLED transition.
  always_ff @(posedge clk) begin
    if (rst) stall_start <= 1'b0;
    else     stall_start <= (state == RUN) && (state_nxt == STALLED);
  end

  // Next run length: saturating count while stalled, zero otherwise.
  always_comb begin
    run_nxt = '0;
    if (stall_active) run_nxt = (run_len == 16'hFFFF) ? run_len : run_len + 16'd1;
  end

  // Run length register; clr_cnt deliberately has no effect here.
  always_ff @(posedge clk) begin
    if (rst) run_len <= '0;
    else     run_len <= run_nxt;
  end

  // Sticky watchdog, set on the edge where the run reaches the limit; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)                                    wdog_timeout <= 1'b0;
    else if (stall_active && run_nxt == WDOG_LV) wdog_timeout <= 1'b1;
  end

  // Per-source saturating stall counters; clr_cnt wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || clr_cnt)                  cnt[i] <= '0;
      else if (src[i] && (cnt[i] != '1))   cnt[i] <= cnt[i] + CNT_ONE;
    end
  end

  assign if_stall_cnt  = cnt[0];
  assign id_stall_cnt  = cnt[1];
  assign ex_stall_cnt  = cnt[2];
  assign mem_stall_cnt = cnt[3];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a reference model pushes expected results per
// cycle into a queue; monitors pop and compare. Directed tasks add fixed checks.
module tb_pipeline_ctrl;
  localparam int WL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, s_if, s_id, s_ex, s_mem, clr;
  logic [5:0]    stall;
  logic          stall_active, stall_start, wdog_timeout;
  logic [CW-1:0] if_c, id_c, ex_c, mem_c;
  logic [15:0]   run_len;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]    stall;
    logic          start;
    logic [15:0]   run;
    logic [CW-1:0] c0, c1, c2, c3;
    logic          wd;
  } exp_t;

  exp_t q[$];

  // reference model state
  logic          m_stalled = 0, m_start = 0, m_wd = 0;
  logic [15:0]   m_run = 0;
  logic [CW-1:0] m_cnt [4] = '{default: '0};

  pipeline_ctrl #(.WDOG_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(s_if), .stallreq_from_id(s_id),
    .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
    .clr_cnt(clr), .stall(stall), .stall_active(stall_active),
    .stall_start(stall_start),
    .if_stall_cnt(if_c), .id_stall_cnt(id_c), .ex_stall_cnt(ex_c), .mem_stall_cnt(mem_c),
    .run_len(run_len), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  // Combinational check mid-cycle against the pending expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      total++;
      if (stall !== q[0].stall || stall_active !== (q[0].stall != 0)) begin
        bad++;
        $display("FAIL stall_comb: got stall=%b act=%b want stall=%b", stall, stall_active, q[0].stall);
      end
    end
  end

  // Registered check just after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (stall_start !== e.start || run_len !== e.run || wdog_timeout !== e.wd ||
          if_c !== e.c0 || id_c !== e.c1 || ex_c !== e.c2 || mem_c !== e.c3) begin
        bad++;
        $display("FAIL regs: got start=%b run=%0d wd=%b cnt=%0d/%0d/%0d/%0d want start=%b run=%0d wd=%b cnt=%0d/%0d/%0d/%0d",
                 stall_start, run_len, wdog_timeout, if_c, id_c, ex_c, mem_c,
                 e.start, e.run, e.wd, e.c0, e.c1, e.c2, e.c3);
      end
    end
  end

  // Drive one cycle (req = {mem,ex,id,if}), push model expectation, advance past the edge.
  task automatic step(input logic [3:0] req, input logic c, input logic r);
    exp_t e;
    int   srcn;
    logic sa;
    {s_mem, s_ex, s_id, s_if} = req;
    clr = c;
    rst = r;
    srcn = -1;
    e.stall = 6'b000000;
    if (!r) begin
      if (req[3])      begin srcn = 3; e.stall = 6'b011111; end
      else if (req[2]) begin srcn = 2; e.stall = 6'b001111; end
      else if (req[1]) begin srcn = 1; e.stall = 6'b000111; end
      else if (req[0]) begin srcn = 0; e.stall = 6'b000011; end
    end
    sa = (e.stall != 0);
    if (r) begin
      m_stalled = 0; m_start = 0; m_run = 0; m_wd = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    end else begin
      m_start   = !m_stalled && sa;
      m_stalled = sa;
      m_run     = sa ? ((m_run == 16'hFFFF) ? m_run : m_run + 16'd1) : 16'd0;
      if (sa && m_run == 16'(WL)) m_wd = 1;
      for (int i = 0; i < 4; i++) begin
        if (c) m_cnt[i] = '0;
        else if (i == srcn && m_cnt[i] != '1) m_cnt[i] = m_cnt[i] + 1'b1;
      end
    end
    e.start = m_start; e.run = m_run; e.wd = m_wd;
    e.c0 = m_cnt[0]; e.c1 = m_cnt[1]; e.c2 = m_cnt[2]; e.c3 = m_cnt[3];
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    step(4'b0100, 0, 1);
    step(4'b0000, 0, 1);
    total++;
    if (run_len !== 16'd0 || wdog_timeout !== 1'b0 || stall_start !== 1'b0 || id_c !== '0) begin
      bad++; $display("FAIL reset_state: run=%0d wd=%b start=%b idc=%0d want 0", run_len, wdog_timeout, stall_start, id_c);
    end
  endtask

  task automatic test_id_single();
    step(4'b0000, 1, 0);
    step(4'b0010, 0, 0);
    total++;
    if (stall_start !== 1'b1 || id_c !== 4'd1 || run_len !== 16'd1) begin
      bad++; $display("FAIL id_single: start=%b idc=%0d run=%0d want 1 1 1", stall_start, id_c, run_len);
    end
    step(4'b0000, 0, 0);
    total++;
    if (stall_start !== 1'b0 || run_len !== 16'd0) begin
      bad++; $display("FAIL id_release: start=%b run=%0d want 0 0", stall_start, run_len);
    end
  endtask

  task automatic test_priority();
    step(4'b0000, 1, 0);
    for (int i = 0; i < 3; i++) step(4'b0111, 0, 0);
    total++;
    if (ex_c !== 4'd3 || if_c !== 4'd0 || id_c !== 4'd0 || run_len !== 16'd3) begin
      bad++; $display("FAIL priority: ex=%0d if=%0d id=%0d run=%0d want 3 0 0 3", ex_c, if_c, id_c, run_len);
    end
    step(4'b1111, 0, 0);
    total++;
    if (mem_c !== 4'd1 || ex_c !== 4'd3 || stall_start !== 1'b0) begin
      bad++; $display("FAIL priority_mem: mem=%0d ex=%0d start=%b want 1 3 0", mem_c, ex_c, stall_start);
    end
    step(4'b0000, 0, 0);
  endtask

  task automatic test_wdog();
    step(4'b0000, 0, 1);
    for (int i = 0; i < 3; i++) step(4'b1000, 0, 0);
    step(4'b0000, 0, 0);
    total++;
    if (wdog_timeout !== 1'b0) begin
      bad++; $display("FAIL wdog_short: got %b want 0", wdog_timeout);
    end
    for (int i = 0; i < 3; i++) step(4'b1000, 0, 0);
    total++;
    if (wdog_timeout !== 1'b0) begin
      bad++; $display("FAIL wdog_early: got %b want 0", wdog_timeout);
    end
    step(4'b1000, 0, 0);
    total++;
    if (wdog_timeout !== 1'b1 || run_len !== 16'd4) begin
      bad++; $display("FAIL wdog_trip: wd=%b run=%0d want 1 4", wdog_timeout, run_len);
    end
    step(4'b0000, 0, 0);
  endtask

  task automatic test_clr();
    step(4'b0010, 1, 0);
    total++;
    if (id_c !== 4'd0 || mem_c !== 4'd0 || wdog_timeout !== 1'b1 || run_len !== 16'd1) begin
      bad++; $display("FAIL clr: idc=%0d memc=%0d wd=%b run=%0d want 0 0 1 1", id_c, mem_c, wdog_timeout, run_len);
    end
    step(4'b0000, 0, 1);
    total++;
    if (wdog_timeout !== 1'b0) begin
      bad++; $display("FAIL clr_rst_wdog: got %b want 0", wdog_timeout);
    end
  endtask

  task automatic test_rst_mid_stall();
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 1);
    total++;
    if (run_len !== 16'd0 || stall_start !== 1'b0 || ex_c !== 4'd0) begin
      bad++; $display("FAIL rst_mid: run=%0d start=%b exc=%0d want 0 0 0", run_len, stall_start, ex_c);
    end
    step(4'b0100, 0, 0);
    total++;
    if (stall_start !== 1'b1 || run_len !== 16'd1) begin
      bad++; $display("FAIL rst_restall: start=%b run=%0d want 1 1", stall_start, run_len);
    end
    step(4'b0000, 0, 0);
  endtask

  task automatic test_saturate();
    step(4'b0000, 1, 0);
    for (int i = 0; i < 20; i++) step(4'b0010, 0, 0);
    total++;
    if (id_c !== 4'hF || run_len !== 16'd20) begin
      bad++; $display("FAIL saturate: idc=%0h run=%0d want f 20", id_c, run_len);
    end
    step(4'b0000, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rq;
      rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rq = 4'b0000;
      step(rq, ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0));
    end
  endtask

  initial begin
    {s_if, s_id, s_ex, s_mem, clr} = '0;
    rst = 1'b1;
    #2;
    test_reset();
    test_id_single();
    test_priority();
    test_wdog();
    test_clr();
    test_rst_mid_stall();
    test_saturate();
    test_random();
    step(4'b0000, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
